// File: rtl/spi_master_mc.sv
// spi_master_mc: configurable multi-channel SPI master.
// One command/response handshake drives any of NUM_SS slave selects. Each
// command carries its own word length, clock divider, CPOL/CPHA mode and an
// SS-hold flag so that several words can be sent as one chip-select burst.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | cmd_ready high, waiting for a command (SS may still be held)
// SWITCH | all selects released for H cycles, SCLK parked at the new CPOL
// SETUP  | select asserted, SCLK at CPOL, first MOSI bit on the wire
// SHIFT  | 2*(len+1) SCLK edges, one every H cycles
// HOLD   | SCLK back at CPOL for H cycles after the last edge
// GAP    | select released, minimum SS-high time before the next command
module spi_master_mc #(
  parameter int DATA_W = 32,
  parameter int NUM_SS = 3,
  parameter int DIV_W  = 8,
  localparam int LEN_W = $clog2(DATA_W),
  localparam int SS_W  = $clog2(NUM_SS)
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [SS_W-1:0]   cmd_ss,
  input  logic              cmd_cpol,
  input  logic              cmd_cpha,
  input  logic [DIV_W-1:0]  cmd_div,
  input  logic              cmd_hold,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic              spi_SCLK,
  output logic              spi_MOSI,
  input  logic              spi_MISO,
  output logic [NUM_SS-1:0] spi_SS_n
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SWITCH = 3'd1;
  localparam logic [2:0] ST_SETUP  = 3'd2;
  localparam logic [2:0] ST_SHIFT  = 3'd3;
  localparam logic [2:0] ST_HOLD   = 3'd4;
  localparam logic [2:0] ST_GAP    = 3'd5;

  localparam logic [SS_W:0] NUM_SS_L = (SS_W+1)'(NUM_SS);

  logic [2:0]        state;
  logic [DIV_W-1:0]  tmr;
  logic [DIV_W-1:0]  div_q;
  logic [LEN_W-1:0]  len_q;
  logic [SS_W-1:0]   ss_q;
  logic              cpol_q;
  logic              cpha_q;
  logic              hold_q;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [LEN_W:0]    edge_left;
  logic              held_q;
  logic [SS_W-1:0]   held_ss;
  logic              held_cpol;

  logic [DATA_W-1:0] tx_nxt;
  logic              lead;
  logic              last_edge;
  logic              do_sample;
  logic              do_change;
  logic              ss_bad;
  logic              need_switch;

  // Active-low one-cold decode; an out-of-range index selects nobody.
  function automatic logic [NUM_SS-1:0] ss_decode(input logic [SS_W-1:0] idx);
    ss_decode = '1;
    for (int i = 0; i < NUM_SS; i++)
      if (idx == SS_W'(i)) ss_decode[i] = 1'b0;
  endfunction

  // Edge classification: a leading edge moves SCLK away from its idle level.
  always_comb begin
    tx_nxt      = tx_sr << 1;
    lead        = (spi_SCLK == cpol_q);
    last_edge   = (state == ST_SHIFT) && (edge_left == (LEN_W+1)'(1));
    do_sample   = cpha_q ? !lead : lead;
    do_change   = cpha_q ? lead : (!lead && !last_edge);
    ss_bad      = ({1'b0, ss_q} >= NUM_SS_L);
    need_switch = held_q && ((cmd_ss != held_ss) || (cmd_cpol != held_cpol));
  end

  // Sequencer, shift registers and registered SPI/handshake outputs.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state     <= ST_IDLE;
      tmr       <= '0;
      div_q     <= '0;
      len_q     <= '0;
      ss_q      <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      hold_q    <= 1'b0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      edge_left <= '0;
      held_q    <= 1'b0;
      held_ss   <= '0;
      held_cpol <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      spi_SCLK  <= 1'b0;
      spi_MOSI  <= 1'b0;
      spi_SS_n  <= '1;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            div_q     <= cmd_div;
            len_q     <= cmd_len;
            ss_q      <= cmd_ss;
            cpol_q    <= cmd_cpol;
            cpha_q    <= cmd_cpha;
            hold_q    <= cmd_hold;
            tx_sr     <= cmd_data;
            rx_sr     <= '0;
            tmr       <= cmd_div;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            spi_SCLK  <= cmd_cpol;
            if (need_switch) begin
              state    <= ST_SWITCH;
              spi_SS_n <= '1;
            end else begin
              state    <= ST_SETUP;
              spi_SS_n <= ss_decode(cmd_ss);
              spi_MOSI <= cmd_data[cmd_len];
            end
          end
        end
        ST_SWITCH: begin
          if (tmr != '0) begin
            tmr <= tmr - 1'b1;
          end else begin
            state    <= ST_SETUP;
            tmr      <= div_q;
            spi_SS_n <= ss_decode(ss_q);
            spi_MOSI <= tx_sr[len_q];
          end
        end
        ST_SETUP, ST_SHIFT: begin
          if (tmr != '0) begin
            tmr <= tmr - 1'b1;
          end else begin
            tmr      <= div_q;
            spi_SCLK <= ~spi_SCLK;
            if (do_sample) rx_sr <= {rx_sr[DATA_W-2:0], spi_MISO};
            if (do_change) begin
              tx_sr    <= tx_nxt;
              // CPHA=1 re-drives the current bit on the first leading edge,
              // then advances; CPHA=0 advances to the next bit on trailing edges.
              spi_MOSI <= cpha_q ? tx_sr[len_q] : tx_nxt[len_q];
            end
            if (state == ST_SETUP) begin
              edge_left <= {len_q, 1'b1};
              state     <= ST_SHIFT;
            end else begin
              edge_left <= edge_left - 1'b1;
              if (last_edge) state <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (tmr != '0) begin
            tmr <= tmr - 1'b1;
          end else begin
            rsp_valid <= 1'b1;
            rsp_data  <= rx_sr;
            rsp_err   <= ss_bad;
            held_q    <= hold_q;
            held_ss   <= ss_q;
            held_cpol <= cpol_q;
            if (hold_q) begin
              state     <= ST_IDLE;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
            end else begin
              state    <= ST_GAP;
              tmr      <= div_q;
              spi_SS_n <= '1;
            end
          end
        end
        ST_GAP: begin
          if (tmr != '0) begin
            tmr <= tmr - 1'b1;
          end else begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          spi_SS_n  <= '1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_mc.sv
// Directed bench for spi_master_mc: loopback and per-mode slave model.
module tb_spi_master_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_data;
  logic [4:0]  cmd_len;
  logic [1:0]  cmd_ss;
  logic        cmd_cpol;
  logic        cmd_cpha;
  logic [7:0]  cmd_div;
  logic        cmd_hold;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_miso;
  logic [2:0]  spi_ss_n;

  int checks = 0;
  int failures = 0;
  int lat, edges, ss_bad;
  logic [2:0] ss_hist [0:7];

  logic        loopback;
  logic [31:0] slv_word = 32'h12345678;
  int          slv_cnt = 0;
  logic        sclk_prev = 1'b0;
  logic        ss_prev_low = 1'b0;
  logic        slv_bit;
  logic        mon_en = 1'b0;
  int          mon_low = 0;

  spi_master_mc #(.DATA_W(32), .NUM_SS(3), .DIV_W(8)) dut (
    .clk_clk(clk), .reset_reset(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .cmd_len(cmd_len), .cmd_ss(cmd_ss), .cmd_cpol(cmd_cpol), .cmd_cpha(cmd_cpha),
    .cmd_div(cmd_div), .cmd_hold(cmd_hold),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .spi_SCLK(spi_sclk), .spi_MOSI(spi_mosi), .spi_MISO(spi_miso), .spi_SS_n(spi_ss_n)
  );

  always #5 clk = ~clk;

  // Slave on select 0: shifts slv_word out MSB-first, changing on its mode's
  // launch edge; edges are only counted while the select was already low.
  always @(negedge clk) begin
    if (!spi_ss_n[0] && ss_prev_low) begin
      if (spi_sclk !== sclk_prev) begin
        if (cmd_cpha ? (spi_sclk != cmd_cpol) : (spi_sclk == cmd_cpol))
          slv_cnt <= slv_cnt + 1;
      end
    end else if (spi_ss_n[0]) begin
      slv_cnt <= 0;
    end
    ss_prev_low <= !spi_ss_n[0];
    sclk_prev   <= spi_sclk;
  end

  always_comb begin
    int idx;
    idx = cmd_cpha ? (32 - slv_cnt) : (31 - slv_cnt);
    slv_bit = 1'b0;
    if (idx >= 0 && idx <= 31) slv_bit = slv_word[idx];
    spi_miso = loopback ? spi_mosi : slv_bit;
  end

  // Counts cycles with select 1 low while a burst is being watched.
  always @(negedge clk) begin
    if (!mon_en) mon_low <= 0;
    else if (!spi_ss_n[1]) mon_low <= mon_low + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a sample point; returns at the sample point of cycle T+1.
  task automatic issue(input logic [31:0] d, input logic [4:0] l, input logic [1:0] s,
                       input logic pol, input logic pha, input logic [7:0] dv, input logic h);
    int n;
    cmd_data = d; cmd_len = l; cmd_ss = s; cmd_cpol = pol; cmd_cpha = pha;
    cmd_div = dv; cmd_hold = h; cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (cmd_ready !== 1'b1) chk("accept_timeout", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // lat counts cycles from T+1 (lat=1) to the rsp_valid cycle.
  task automatic wait_rsp(input logic [2:0] exp_ss, input int budget);
    logic prev;
    lat = 1; edges = 0; ss_bad = 0; prev = spi_sclk;
    for (int i = 0; i < 8; i++) ss_hist[i] = 3'b000;
    for (int c = 0; c < budget; c++) begin
      if (lat < 8) ss_hist[lat] = spi_ss_n;
      if (rsp_valid === 1'b1) break;
      if (spi_ss_n !== exp_ss) ss_bad++;
      @(posedge clk); #1;
      lat++;
      if (spi_sclk !== prev) edges++;
      prev = spi_sclk;
    end
    chk("rsp_seen", {31'd0, rsp_valid}, 32'd1);
  endtask

  initial begin
    int rsp_cnt;
    rst = 1'b1; cmd_valid = 1'b0; cmd_data = '0; cmd_len = '0; cmd_ss = '0;
    cmd_cpol = 1'b0; cmd_cpha = 1'b0; cmd_div = '0; cmd_hold = 1'b0; loopback = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_ss_n", {29'd0, spi_ss_n}, 32'd7);
    chk("rst_sclk", {31'd0, spi_sclk}, 32'd0);
    chk("rst_mosi", {31'd0, spi_mosi}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Mode 0 loopback, H=2, 8 bits on select 1.
    issue(32'hA5, 5'd7, 2'd1, 1'b0, 1'b0, 8'd1, 1'b0);
    wait_rsp(3'b101, 200);
    chk("t1_latency", lat, 35);
    chk("t1_edges", edges, 16);
    chk("t1_ss_low_span", ss_bad, 0);
    chk("t1_rsp_data", rsp_data, 32'h000000A5);
    chk("t1_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("t1_ss_release", {29'd0, spi_ss_n}, 32'd7);
    chk("t1_gap_ready0", {31'd0, cmd_ready}, 32'd0);
    @(posedge clk); #1;
    chk("t1_gap_ready1", {31'd0, cmd_ready}, 32'd0);
    chk("t1_rsp_pulse", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    chk("t1_ready_back", {31'd0, cmd_ready}, 32'd1);
    chk("t1_idle_busy", {31'd0, busy}, 32'd0);

    // All four modes against the slave model, full 32-bit words, H=1.
    loopback = 1'b0;
    for (int m = 0; m < 4; m++) begin
      issue(32'hDEADBEEF, 5'd31, 2'd0, m[1], m[0], 8'd0, 1'b0);
      wait_rsp(3'b110, 300);
      chk($sformatf("mode%0d_rsp_data", m), rsp_data, 32'h12345678);
      chk($sformatf("mode%0d_sclk_idle", m), {31'd0, spi_sclk}, {31'd0, m[1]});
      chk($sformatf("mode%0d_latency", m), lat, 66);
    end
    loopback = 1'b1;

    // Held burst of three words on select 1.
    mon_en = 1'b1;
    issue(32'h11, 5'd7, 2'd1, 1'b0, 1'b0, 8'd1, 1'b1);
    wait_rsp(3'b101, 200);
    chk("burst1_ss_held", {29'd0, spi_ss_n}, 32'd5);
    chk("burst1_ready", {31'd0, cmd_ready}, 32'd1);
    issue(32'h22, 5'd7, 2'd1, 1'b0, 1'b0, 8'd1, 1'b1);
    wait_rsp(3'b101, 200);
    chk("burst2_latency", lat, 35);
    issue(32'h33, 5'd7, 2'd1, 1'b0, 1'b0, 8'd1, 1'b0);
    wait_rsp(3'b101, 200);
    chk("burst3_rsp_data", rsp_data, 32'h33);
    chk("burst3_ss_release", {29'd0, spi_ss_n}, 32'd7);
    chk("burst3_gap_ready", {31'd0, cmd_ready}, 32'd0);
    @(posedge clk); #1;
    chk("burst3_gap_ready1", {31'd0, cmd_ready}, 32'd0);
    @(posedge clk); #1;
    chk("burst3_ready_back", {31'd0, cmd_ready}, 32'd1);
    mon_en = 1'b0;
    chk("burst_ss_low_cycles", mon_low, 104);

    // Held select 0, then a command to select 2 forces a switch.
    issue(32'h9, 5'd3, 2'd0, 1'b0, 1'b0, 8'd1, 1'b1);
    wait_rsp(3'b110, 200);
    chk("sw_first_rsp", rsp_data, 32'h9);
    issue(32'h6, 5'd3, 2'd2, 1'b0, 1'b0, 8'd1, 1'b0);
    wait_rsp(3'b011, 200);
    chk("sw_gap_c1", {29'd0, ss_hist[1]}, 32'd7);
    chk("sw_gap_c2", {29'd0, ss_hist[2]}, 32'd7);
    chk("sw_sel_c3", {29'd0, ss_hist[3]}, 32'd3);
    chk("sw_latency", lat, 21);
    chk("sw_rsp_data", rsp_data, 32'h6);

    // Out-of-range select: clocks run, nothing selected, error flagged.
    issue(32'hC, 5'd3, 2'd3, 1'b0, 1'b0, 8'd0, 1'b0);
    wait_rsp(3'b111, 200);
    chk("bad_ss_none", ss_bad, 0);
    chk("bad_ss_edges", edges, 8);
    chk("bad_ss_err", {31'd0, rsp_err}, 32'd1);
    chk("bad_ss_latency", lat, 10);

    // Reset in the middle of a CPOL=1 transfer.
    issue(32'hBEEF, 5'd15, 2'd1, 1'b1, 1'b0, 8'd1, 1'b0);
    repeat (12) begin @(posedge clk); #1; end
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_ss_n", {29'd0, spi_ss_n}, 32'd7);
    chk("mid_rst_sclk", {31'd0, spi_sclk}, 32'd0);
    chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_mosi", {31'd0, spi_mosi}, 32'd0);
    rsp_cnt = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (rsp_valid === 1'b1) rsp_cnt++;
    end
    chk("mid_rst_no_rsp", rsp_cnt, 0);
    issue(32'h3C, 5'd7, 2'd0, 1'b0, 1'b1, 8'd1, 1'b0);
    wait_rsp(3'b110, 200);
    chk("post_rst_rsp_data", rsp_data, 32'h3C);
    chk("post_rst_latency", lat, 35);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
